// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide RAM bus bundle between the pipeline/RAM side (master)
// and mem_arbiter (slave).
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        stall_req_if;
   logic        stall_req_mem;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
      input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
             stall_req_if, stall_req_mem
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
      output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
             stall_req_if, stall_req_mem
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide unified RAM port arbiter for IF and MEM with little-endian byte sequencing.
// Optional MEM_ARBITER_IO_GUARD_EN: holds off stores to the IO region while io_buffer_full.
module mem_arbiter (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         branch_flag_in,
`ifdef MEM_ARBITER_IO_GUARD_EN
   input  logic         io_buffer_full,
`endif
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

   state_t      state, state_nx;
   owner_t      owner, owner_nx;
   logic [2:0]  issue, issue_nx, rcv, rcv_nx, nbytes, nbytes_nx, size_n;
   logic [31:0] addr, addr_nx, wdata, wdata_nx, rbuf, rbuf_nx;
   logic [31:0] if_data_q, if_data_nx, mem_rdata_q, mem_rdata_nx, ram_a_q, ram_a_nx;
   logic [7:0]  ram_dout_q, ram_dout_nx;
   logic        wr_q, wr_nx, if_done_q, if_done_nx, mem_done_q, mem_done_nx;
   logic        store_blocked;
   logic [31:0] assembled, wshift;

`ifdef MEM_ARBITER_IO_GUARD_EN
   assign store_blocked = bus.mem_we && (bus.mem_addr[17:16] == 2'b11) && io_buffer_full;
`else
   assign store_blocked = 1'b0;
`endif

   always_comb begin
      case (bus.mem_size)
         2'b00:   size_n = 3'd1;
         2'b01:   size_n = 3'd2;
         default: size_n = 3'd4;
      endcase
   end

   assign assembled = rbuf | ({24'b0, bus.ram_din} << {rcv[1:0], 3'b000});
   assign wshift    = wdata >> {issue[1:0], 3'b000};

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      issue_nx     = issue;
      rcv_nx       = rcv;
      nbytes_nx    = nbytes;
      addr_nx      = addr;
      wdata_nx     = wdata;
      rbuf_nx      = rbuf;
      if_data_nx   = if_data_q;
      mem_rdata_nx = mem_rdata_q;
      ram_a_nx     = ram_a_q;
      ram_dout_nx  = ram_dout_q;
      wr_nx        = 1'b0;
      if_done_nx   = 1'b0;
      mem_done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_req && !store_blocked) begin
               owner_nx  = OWN_MEM;
               addr_nx   = bus.mem_addr;
               wdata_nx  = bus.mem_wdata;
               nbytes_nx = size_n;
               rbuf_nx   = '0;
               ram_a_nx  = bus.mem_addr;
               issue_nx  = 3'd1;
               rcv_nx    = '0;
               if (bus.mem_we) begin
                  state_nx    = WR;
                  wr_nx       = 1'b1;
                  ram_dout_nx = bus.mem_wdata[7:0];
               end else begin
                  state_nx = RD;
               end
            end else if (bus.if_req && !branch_flag_in) begin
               owner_nx  = OWN_IF;
               addr_nx   = bus.if_addr;
               nbytes_nx = 3'd4;
               rbuf_nx   = '0;
               ram_a_nx  = bus.if_addr;
               issue_nx  = 3'd1;
               rcv_nx    = '0;
               state_nx  = RD;
            end
         end
         RD: begin
            if (owner == OWN_IF && branch_flag_in) begin
               state_nx = IDLE;
            end else begin
               // issue equals the cycle index k; byte k-2 is on ram_din at the end of cycle k
               issue_nx = issue + 3'd1;
               if (issue < nbytes) ram_a_nx = addr + {29'b0, issue};
               if (issue >= 3'd2) begin
                  rbuf_nx = assembled;
                  rcv_nx  = rcv + 3'd1;
                  if (rcv == nbytes - 3'd1) begin
                     state_nx = DONE;
                     if (owner == OWN_IF) begin
                        if_data_nx = assembled;
                        if_done_nx = 1'b1;
                     end else begin
                        mem_rdata_nx = assembled;
                        mem_done_nx  = 1'b1;
                     end
                  end
               end
            end
         end
         WR: begin
            if (issue < nbytes) begin
               ram_a_nx    = addr + {29'b0, issue};
               ram_dout_nx = wshift[7:0];
               wr_nx       = 1'b1;
               issue_nx    = issue + 3'd1;
            end else begin
               state_nx    = DONE;
               mem_done_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= IDLE;
         owner       <= OWN_IF;
         issue       <= '0;
         rcv         <= '0;
         nbytes      <= '0;
         addr        <= '0;
         wdata       <= '0;
         rbuf        <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         wr_q        <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else if (rdy_in) begin
         state       <= state_nx;
         owner       <= owner_nx;
         issue       <= issue_nx;
         rcv         <= rcv_nx;
         nbytes      <= nbytes_nx;
         addr        <= addr_nx;
         wdata       <= wdata_nx;
         rbuf        <= rbuf_nx;
         if_data_q   <= if_data_nx;
         mem_rdata_q <= mem_rdata_nx;
         ram_a_q     <= ram_a_nx;
         ram_dout_q  <= ram_dout_nx;
         wr_q        <= wr_nx;
         if_done_q   <= if_done_nx;
         mem_done_q  <= mem_done_nx;
      end
   end

   assign bus.if_data       = if_data_q;
   assign bus.if_done       = if_done_q;
   assign bus.mem_rdata     = mem_rdata_q;
   assign bus.mem_done      = mem_done_q;
   assign bus.ram_a         = ram_a_q;
   assign bus.ram_dout      = ram_dout_q;
   assign bus.ram_wr        = wr_q & rdy_in;
   assign bus.stall_req_if  = bus.if_req & ~if_done_q;
   assign bus.stall_req_mem = bus.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences and random
// transactions checked against a byte-image memory model.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n, rdy, branch;
`ifdef MEM_ARBITER_IO_GUARD_EN
   logic io_full;
`endif
   int checks = 0;
   int failures = 0;

   logic [7:0]  model_mem [0:65535];
   logic [7:0]  ram [0:65535];
   logic [39:0] wr_log [$];

   mem_arbiter_if bus();

   mem_arbiter dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .rdy_in         (rdy),
      .branch_flag_in (branch),
`ifdef MEM_ARBITER_IO_GUARD_EN
      .io_buffer_full (io_full),
`endif
      .bus            (bus)
   );

   always #5 clk = ~clk;

   // RAM: one-cycle read latency, held by the global ready; reloaded from the model during reset
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 65536; i++) ram[i] = model_mem[i];
         bus.ram_din <= '0;
      end else begin
         if (rdy) bus.ram_din <= ram[bus.ram_a[15:0]];
         if (bus.ram_wr) begin
            ram[bus.ram_a[15:0]] = bus.ram_dout;
            wr_log.push_back({bus.ram_a, bus.ram_dout});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic int nbytes_of(input logic is_if, input logic [1:0] size);
      if (is_if) return 4;
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      logic [31:0] p;
      v = '0;
      for (int i = 0; i < n; i++) begin
         p = a + 32'(i);
         v = v | (32'(model_mem[p[15:0]]) << (8 * i));
      end
      return v;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      model_mem[a[15:0]] = d;
   endtask

   // Called at a negedge with the arbiter idle; that cycle is cycle 0.
   task automatic run_txn(input string tag, input logic is_if, input logic we,
                          input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int sf, input int sl,
                          input int bf, input int bl, input logic [31:0] exp_data,
                          input int exp_lat);
      int n, lat, bad, start;
      logic done_now, other, stall;
      logic [31:0] got, p, wb;
      n = nbytes_of(is_if, size);
      lat = -1; bad = 0; got = '0;
      start = wr_log.size();
      if (is_if) begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end else begin
         bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = size;
         bus.mem_addr = addr; bus.mem_wdata = wdata;
      end
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc > 0) @(negedge clk);
         rdy    = !(cyc >= sf && cyc < sf + sl);
         branch = (bl > 0 && cyc >= bf && cyc < bf + bl);
         #1;
         done_now = is_if ? bus.if_done : bus.mem_done;
         other    = is_if ? bus.mem_done : bus.if_done;
         stall    = is_if ? bus.stall_req_if : bus.stall_req_mem;
         if (other) bad++;
         if (stall !== !done_now) bad++;
         if (!rdy && bus.ram_wr) bad++;
         if (!we && sl == 0 && bl == 0 && cyc >= 1 && cyc <= n && bus.ram_a !== addr + 32'(cyc - 1)) bad++;
         if (done_now) begin
            lat = cyc;
            got = is_if ? bus.if_data : bus.mem_rdata;
            break;
         end
      end
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
      rdy = 1'b1; branch = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         if (bus.if_done || bus.mem_done) bad++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_proto"}, bad, 0);
      if (!we) begin
         check({tag, "_data"}, got, exp_data);
         check({tag, "_nowrite"}, wr_log.size() - start, 0);
      end else begin
         check({tag, "_nwrites"}, wr_log.size() - start, n);
         for (int i = 0; i < n; i++) begin
            p = addr + 32'(i);
            wb = wdata >> (8 * i);
            if (start + i < wr_log.size())
               check($sformatf("%s_wr%0d", tag, i), wr_log[start + i], {p, wb[7:0]});
            model_mem[p[15:0]] = wb[7:0];
         end
      end
   endtask

   typedef struct {
      logic        is_if;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          sf, sl, bf, bl;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs [14];
   int   mem_lat, if_lat, seen, start, n, base, sf, sl;
   logic [31:0] mem_val, if_val, addr, wdata, exp, p;
   logic is_if, we;
   logic [1:0] size;

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,           0, 0, 0, 0, 32'h9300_0013, 6};
      vecs[1]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0202, 32'h0,           0, 0, 0, 0, 32'h0000_CDAB, 4};
      vecs[2]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0300, 32'hDEAD_BEEF,   0, 0, 0, 0, 32'h0,         5};
      vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0,           0, 0, 0, 0, 32'hDEAD_BEEF, 6};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0301, 32'h0,           2, 3, 0, 0, 32'h0000_00BE, 6};
      vecs[5]  = '{1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_1234,   0, 0, 0, 0, 32'h0,         3};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0,           0, 0, 0, 0, 32'h0000_0012, 3};
      vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0,           0, 0, 0, 0, 32'h5612_3477, 6};
      vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0400, 32'h1234_56A5,   0, 0, 0, 0, 32'h0,         2};
      vecs[9]  = '{1'b0, 1'b0, 2'b01, 32'h0000_03FF, 32'h0,           0, 0, 0, 0, 32'h0000_A511, 4};
      vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h0000_0300, 32'h0,           1, 2, 0, 0, 32'hDEAD_BEEF, 8};
      vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,           0, 0, 0, 2, 32'h9300_0013, 8};
      vecs[12] = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0,           0, 0, 1, 3, 32'hDEAD_BEEF, 6};
      vecs[13] = '{1'b0, 1'b1, 2'b11, 32'h0003_0000, 32'hCAFE_F00D,   0, 0, 0, 0, 32'h0,         5};

      rst_n = 1'b0; rdy = 1'b1; branch = 1'b0;
`ifdef MEM_ARBITER_IO_GUARD_EN
      io_full = 1'b0;
`endif
      bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      bus.mem_size = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
      for (int i = 0; i < 65536; i++) model_mem[i] = 8'($urandom);
      poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h93);
      poke(32'h202, 8'hAB); poke(32'h203, 8'hCD);
      poke(32'hFFFE, 8'h77); poke(32'h0001, 8'h56); poke(32'h03FF, 8'h11);

      repeat (3) @(negedge clk);
      #1;
      check("rst_if_data", bus.if_data, 0);
      check("rst_mem_rdata", bus.mem_rdata, 0);
      check("rst_dones", {bus.if_done, bus.mem_done}, 0);
      check("rst_ram_a", bus.ram_a, 0);
      check("rst_ram_dout", bus.ram_dout, 0);
      check("rst_ram_wr", bus.ram_wr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr,
                 vecs[i].wdata, vecs[i].sf, vecs[i].sl, vecs[i].bf, vecs[i].bl,
                 vecs[i].exp_data, vecs[i].exp_lat);

      // simultaneous IF and MEM requests: MEM first, IF accepted after the idle cycle
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b01; bus.mem_addr = 32'h202;
      mem_lat = -1; if_lat = -1; mem_val = '0; if_val = '0;
      for (int cyc = 0; cyc < 30 && if_lat < 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         if (bus.mem_done) begin mem_lat = cyc; mem_val = bus.mem_rdata; bus.mem_req = 1'b0; end
         if (bus.if_done)  begin if_lat = cyc;  if_val = bus.if_data;    bus.if_req = 1'b0; end
      end
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
      check("both_mem_lat", mem_lat, 4);
      check("both_mem_data", mem_val, 32'h0000_CDAB);
      check("both_if_lat", if_lat, 11);
      check("both_if_data", if_val, 32'h9300_0013);
      @(negedge clk);

      // branch in cycle 3 aborts the fetch; a fetch raised in cycle 4 is accepted at once
      start = wr_log.size(); seen = 0; if_lat = -1; if_val = '0;
      exp = model_read(32'h202, 4);
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 3) begin branch = 1'b1; bus.if_req = 1'b0; end
         if (cyc == 4) begin branch = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h202; end
         #1;
         if (bus.if_done) begin
            seen++;
            if (if_lat < 0) begin if_lat = cyc; if_val = bus.if_data; end
            bus.if_req = 1'b0;
         end
      end
      bus.if_req = 1'b0;
      check("abort_done_count", seen, 1);
      check("abort_refetch_lat", if_lat, 10);
      check("abort_refetch_data", if_val, exp);
      check("abort_nowrite", wr_log.size() - start, 0);

      // asynchronous reset in the middle of a store
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b10;
      bus.mem_addr = 32'h500; bus.mem_wdata = 32'h1122_3344;
      @(negedge clk); @(negedge clk);
      #1;
      check("pre_rst_ram_wr", bus.ram_wr, 1);
      #1 rst_n = 1'b0;
      #1;
      start = wr_log.size();
      check("async_rst_ram_wr", bus.ram_wr, 0);
      check("async_rst_ram_a", bus.ram_a, 0);
      check("async_rst_ram_dout", bus.ram_dout, 0);
      bus.mem_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk); #1;
         if (bus.mem_done || bus.ram_wr) seen++;
      end
      check("async_rst_dropped", seen + wr_log.size() - start, 0);

`ifdef MEM_ARBITER_IO_GUARD_EN
      // store to IO region held off until io_buffer_full falls in cycle 5
      io_full = 1'b1; start = wr_log.size(); mem_lat = -1; seen = 0;
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b10;
      bus.mem_addr = 32'h0003_0000; bus.mem_wdata = 32'h0A0B_0C0D;
      for (int cyc = 0; cyc < 30 && mem_lat < 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 5) io_full = 1'b0;
         #1;
         if (bus.ram_wr && cyc < 6) seen++;
         if (bus.mem_done) begin mem_lat = cyc; bus.mem_req = 1'b0; end
      end
      bus.mem_req = 1'b0;
      check("guard_lat", mem_lat, 10);
      check("guard_early_write", seen, 0);
      check("guard_nwrites", wr_log.size() - start, 4);
      for (int i = 0; i < 4; i++) begin
         p = 32'h0003_0000 + 32'(i);
         model_mem[p[15:0]] = 8'(32'h0A0B_0C0D >> (8 * i));
      end
      @(negedge clk);
`endif

      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 2))
            0:       begin is_if = 1'b1; we = 1'b0; end
            1:       begin is_if = 1'b0; we = 1'b0; end
            default: begin is_if = 1'b0; we = 1'b1; end
         endcase
         size  = 2'($urandom);
         addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'h0000_1000 + 32'($urandom_range(0, 255));
         wdata = $urandom;
         n     = nbytes_of(is_if, size);
         base  = we ? n + 1 : n + 2;
         sf = 1; sl = 0;
         if ($urandom_range(0, 2) == 0) begin
            sl = $urandom_range(1, 3);
            sf = $urandom_range(1, base - 1);
         end
         exp = we ? 32'h0 : model_read(addr, n);
         run_txn($sformatf("rand%0d", t), is_if, we, size, addr, wdata, sf, sl, 0, 0, exp, base + sl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single byte-wide unified RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM). It splits 1/2/4-byte accesses into byte transfers, assembles little-endian read data, and produces the per-stage stall requests from which the pipeline controller derives `stall[5:0]`. A taken branch aborts an in-flight fetch so the flushed pipeline registers are not refilled with stale instructions.

## Interface
- No parameters. Widths are fixed: 32-bit addresses and data, 8-bit RAM data.
- `clk_in  in  1`  system clock.
- `rst_in  in  1`  **asynchronous, active-low reset.**
- `rdy_in  in  1`  global ready. While low, all state is held.
- `branch_flag_in  in  1`  taken-branch flush from EX.
- `if_req  in  1`  fetch request. Held high until `if_done`.
- `if_addr  in  32`  fetch address.
- `if_data  out  32`  fetched instruction. Valid while `if_done` is high.
- `if_done  out  1`  one-cycle completion pulse for a fetch.
- `mem_req  in  1`  load/store request. Held high until `mem_done`.
- `mem_we  in  1`  1 = store, 0 = load.
- `mem_size  in  2`  00 = byte, 01 = half, 10 or 11 = word.
- `mem_addr  in  32`  load/store address.
- `mem_wdata  in  32`  store data.
- `mem_rdata  out  32`  load data, zero-extended. Valid while `mem_done` is high.
- `mem_done  out  1`  one-cycle completion pulse for a load/store.
- `ram_din  in  8`  RAM read byte.
- `ram_dout  out  8`  RAM write byte.
- `ram_a  out  32`  RAM byte address.
- `ram_wr  out  1`  RAM write enable. 1 = write.
- `stall_req_if  out  1`  combinational: `if_req & ~if_done`.
- `stall_req_mem  out  1`  combinational: `mem_req & ~mem_done`.

## Operation
- States: IDLE, RD, WR, DONE. Owner register records IF or MEM. A 3-bit issue counter and a 3-bit receive counter track byte progress.
- Reset values: state IDLE, counters 0, `if_data` 0, `mem_rdata` 0, `if_done` 0, `mem_done` 0, `ram_a` 0, `ram_dout` 0, `ram_wr` 0.
- Arbitration in IDLE:
  - `mem_req` wins over `if_req`, because MEM holds the older instruction.
  - An IF request is not accepted while `branch_flag_in` is high.
  - MEM with `mem_we=1` goes to WR. MEM with `mem_we=0` goes to RD. IF goes to RD with n = 4.
- Once accepted, the request inputs are not re-sampled. Address, data and size are latched at acceptance.
- Byte count n: 1 for byte, 2 for half, 4 for word.
- Byte i uses address `addr + i` (32-bit wrap).
  - Reads place byte i into bits `[8i+7:8i]`.
  - Writes drive `wdata[8i+7:8i]`.
- RD: drive `ram_a` for bytes 0..n-1 on consecutive cycles with `ram_wr=0`. Each byte returns on `ram_din` in the cycle after its address.
- WR: drive `ram_a`/`ram_dout` for bytes 0..n-1 on consecutive cycles with `ram_wr=1`.
- DONE lasts one cycle:
  - Pulses the owner's done signal.
  - `ram_wr=0`.
  - No request is accepted in this cycle.
  - Always returns to IDLE.
- Branch abort: `branch_flag_in` high while in RD with owner IF moves to IDLE at the next edge, with no `if_done` and no RAM writes.
  - A branch arriving in the DONE cycle does not cancel `if_done`; IF discards that instruction.
  - A branch never affects MEM-owned transactions.

## Timing
- Cycle k is the cycle following acceptance edge E0 by k cycles.
- n-byte read: addresses in cycles 1..n. Data is sampled at the end of cycles 2..n+1. DONE is in cycle n+2.
  - Word fetch: `if_done` in cycle 6.
  - Byte load: `mem_done` in cycle 3.
- n-byte write: `ram_wr=1` in cycles 1..n. DONE is in cycle n+1.
  - Word store: `mem_done` in cycle 5.
- Minimum spacing between two acceptances: n+3 cycles for reads, n+2 cycles for writes.
- `rdy_in` low freezes every register, including pending counters and outputs. `ram_wr` is forced to 0 during those cycles.
- Asynchronous reset mid-transaction:
  - All outputs return to their reset values immediately.
  - The partial transaction is dropped. A partial write may leave some bytes already written.

## Configuration
- `MEM_ARBITER_IO_GUARD_EN`
  - Defined: adds input `io_buffer_full  in  1`.
    - A MEM store with `mem_addr[17:16]==2'b11` is not accepted while `io_buffer_full` is high. The arbiter stays in IDLE.
    - IF requests may be granted meanwhile.
    - Reads to that region are unaffected.
  - Undefined: the port is absent, and stores are accepted regardless of address.

## Test plan
- Word fetch from `0x100`, RAM bytes 13 00 00 93 → `ram_a` 0x100..0x103 in cycles 1–4; `if_data=0x93000013` with `if_done` in cycle 6; `stall_req_if` high in cycles 0–5.
- `if_req` and `mem_req` (load half at `0x202`, bytes AB CD) raised in the same cycle → MEM served first with `mem_rdata=0x0000CDAB` in cycle 4; IF accepted at the edge after DONE.
- Word store of `0xDEADBEEF` to `0x300` → writes EF, BE, AD, DE to 0x300..0x303 in cycles 1–4; `mem_done` in cycle 5; no extra `ram_wr` cycles.
- `branch_flag_in` pulsed in cycle 3 of a fetch → IDLE at the next edge; no `if_done`; a new fetch is accepted normally afterwards.
- `rdy_in` low for cycles 2–4 of a byte load → all state held with `ram_wr=0`; `mem_done` delayed by exactly 3 cycles, with correct data.
- With `MEM_ARBITER_IO_GUARD_EN`: store to `0x30000` while `io_buffer_full=1` → not accepted; accepted at the first edge after `io_buffer_full` falls.
